dmem_lsu_ctrl: RTL
==================

Name: dmem_lsu_ctrl

Overview:
Parametrised data memory with a request/response handshake and RISC-V load/store size handling. It supports byte, halfword and word access with sign/zero extension and byte-lane merging on stores, and flags misaligned, out-of-range and illegal accesses. After reset, a counter-driven sequencer initialises the memory one word per cycle, as a real RAM macro would require. Sits between the MEM stage and the data RAM array.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr
DEPTH, 64, number of 32-bit words; power of two, >= 4
INIT_MODE, 1, reset fill pattern: 0 = all zero, 1 = word i holds i zero-extended

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present this cycle
req_ready  out  1  block accepts a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_size  in  3  RISC-V funct3 of the load/store
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result, extended
rsp_err  out  1  access faulted, no side effect
init_done  out  1  initialisation complete

Behaviour:
- Reset is synchronous: rst_n sampled low at a posedge -> state INIT, init counter 0. Outputs after reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- States: INIT, RUN. Reset always returns to INIT, including mid-operation; any pending response is dropped.
- INIT: on the k-th posedge with rst_n high (k=0..DEPTH-1), word k is written with the INIT_MODE pattern. The edge that writes word DEPTH-1 moves the state to RUN. init_done is 1 and req_ready is 1 from the next cycle; DEPTH cycles in total.
- During INIT, req_valid is ignored and produces no response.
- RUN: req_ready=1 every cycle. Accept = req_valid & req_ready. Back-to-back requests are allowed, one per cycle.
- Latency 1: rsp_valid=1 on the cycle after accept. rsp_rdata and rsp_err are registered with it.
- Cycles without a response: rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Address decode: offset = req_addr[1:0]; word index = req_addr[log2(DEPTH)+1:2].
- Error conditions (rsp_err=1, rsp_rdata=0, memory unchanged):
  - req_addr >= 4*DEPTH
  - halfword access with addr[0]=1
  - word access with addr[1:0]!=0
  - load funct3 in {011,110,111}
  - store funct3 not in {000,001,010}
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. The byte or halfword at the offset is selected; LB/LH sign-extend, LBU/LHU zero-extend.
- Stores: 000 SB, 001 SH, 010 SW. Store data is taken from the low bits of req_wdata. Only the addressed byte lanes are written; other bytes of the word are preserved.
- Store response: rsp_valid=1, rsp_rdata=0, rsp_err per checks. The write takes effect at the accept edge.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data.
- Read data is taken from the array at the accept edge, so stale-data hazards are not possible.

Test Plan:
- Reset for 2 cycles, release (DEPTH=64, INIT_MODE=1) -> init_done=0 and req_ready=0 for 64 cycles, then 1. LW 0x14 -> next cycle rsp_valid=1, rsp_rdata=0x00000005, rsp_err=0.
- SW 0x08 data 0xDEADBEEF, followed back-to-back by LB 0x08, LBU 0x0B, LH 0x0A, LHU 0x08 -> responses, respectively:
  - SW: rdata 0
  - LB 0x08: 0xFFFFFFEF
  - LBU 0x0B: 0x000000DE
  - LH 0x0A: 0xFFFFDEAD
  - LHU 0x08: 0x0000BEEF
  - One response per cycle, no gaps.
- SB 0x11 data 0x123456AA, then LW 0x10 -> 0x0000AA04. Then SH 0x12 data 0xFFFF1234, then LW 0x10 -> 0x1234AA04.
- Fault cases, each returning rsp_err=1 and rdata=0:
  - LW 0x06
  - SH 0x13 data 0xBEEF (word 4 unchanged afterwards)
  - LW 0x100 (out of range)
  - load funct3 011
  - store funct3 100
- req_valid=1 with SW 0x00 held throughout INIT -> no rsp_valid, and word 0 still reads 0 after init.
- In RUN, issue SW 0x00 data 0xFFFFFFFF, then assert rst_n=0 on the next cycle -> rsp_valid=0 on the cycle after the reset edge, init replays for 64 cycles, then LW 0x00 returns 0x00000000.

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// Data memory behind a valid/ready load-store port: RISC-V byte/half/word access,
// single-cycle registered response, and a word-per-cycle fill sequence after reset.
module dmem_lsu_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int INIT_MODE  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_size,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_init_cnt;
   logic [31:0]      r_mem [DEPTH];
   logic             r_req_ready;
   logic             r_init_done;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_rdata;
   logic             r_rsp_err;

   logic [1:0]       w_off;
   logic [4:0]       w_shamt;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_word;
   logic [31:0]      w_shifted;
   logic [31:0]      w_ldata;
   logic [31:0]      w_smask;
   logic [31:0]      w_sdata;
   logic [31:0]      w_sword;
   logic             w_oor;
   logic             w_misal;
   logic             w_badfn;
   logic             w_err;
   logic             w_accept;

   always_comb begin
      w_off     = req_addr[1:0];
      w_shamt   = {w_off, 3'b000};
      w_idx     = req_addr[IDX_W+1:2];
      w_word    = r_mem[w_idx];
      w_shifted = w_word >> w_shamt;
      w_accept  = req_valid & r_req_ready;

      // Anything above the array's byte span is out of range, whatever ADDR_WIDTH is.
      w_oor   = (req_addr >> (IDX_W + 2)) != '0;
      w_misal = ((req_size[1:0] == 2'b01) && w_off[0]) ||
                ((req_size[1:0] == 2'b10) && (w_off != 2'b00));
      if (req_we)
         w_badfn = (req_size != 3'b000) && (req_size != 3'b001) && (req_size != 3'b010);
      else
         w_badfn = (req_size == 3'b011) || (req_size == 3'b110) || (req_size == 3'b111);
      w_err = w_oor | w_misal | w_badfn;

      case (req_size)
         3'b000:  w_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_ldata = w_word;
         3'b100:  w_ldata = {24'h0, w_shifted[7:0]};
         3'b101:  w_ldata = {16'h0, w_shifted[15:0]};
         default: w_ldata = '0;
      endcase

      // Replicate store data across lanes, then keep only the addressed ones.
      case (req_size[1:0])
         2'b00: begin
            w_smask = 32'h0000_00FF << w_shamt;
            w_sdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_smask = 32'h0000_FFFF << w_shamt;
            w_sdata = {2{req_wdata[15:0]}};
         end
         default: begin
            w_smask = '1;
            w_sdata = req_wdata;
         end
      endcase
      w_sword = (w_word & ~w_smask) | (w_sdata & w_smask);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_init_cnt  <= '0;
         r_req_ready <= 1'b0;
         r_init_done <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_mem[r_init_cnt] <= (INIT_MODE == 1) ? 32'(r_init_cnt) : '0;
               if (r_init_cnt == IDX_W'(DEPTH - 1)) begin
                  r_state     <= S_RUN;
                  r_req_ready <= 1'b1;
                  r_init_done <= 1'b1;
               end else begin
                  r_init_cnt <= r_init_cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_rsp_valid <= 1'b1;
                  if (w_err)
                     r_rsp_err <= 1'b1;
                  else if (req_we)
                     r_mem[w_idx] <= w_sword;
                  else
                     r_rsp_rdata <= w_ldata;
               end
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign init_done = r_init_done;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
